// File: rtl/frame_config_writer_if.sv
// Bundle for frame_config_writer: the configuration word stream coming in
// and the frame-latch drive going out.
interface frame_config_writer_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
);
    logic [31:0]                s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic                       abort;
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport master (
        output s_data,
        output s_valid,
        output abort,
        input  s_ready,
        input  FrameData,
        input  FrameStrobe,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  abort,
        output s_ready,
        output FrameData,
        output FrameStrobe,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/frame_config_writer.sv
// Takes a header plus one data word per frame and drives the frame latches.
// Every frame goes through LOAD, STROBE and HOLD.
module frame_config_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
) (
    input  logic                 CLK,
    input  logic                 resetn,
    frame_config_writer_if.slave cfg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [7:0]                 SyncByte  = 8'hA5;
    localparam logic [8:0]                 MaxSum    = 9'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);
    localparam logic [MaxFramesPerCol-1:0] StrobeNone = {MaxFramesPerCol{1'b0}};

    state_e                     state_q, state_d;
    logic [7:0]                 index_q, index_d;
    logic [7:0]                 remaining_q, remaining_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] frame_strobe_q, frame_strobe_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       ready_s;
    logic                       accept_s;
    logic [8:0]                 sum_s;
    logic                       header_ok_s;

    // abort wins over s_valid: no word is taken while it is high.
    assign ready_s     = resetn && !cfg.abort && ((state_q == IDLE) || (state_q == LOAD));
    assign accept_s    = ready_s && cfg.s_valid;
    assign sum_s       = {1'b0, cfg.s_data[23:16]} + {1'b0, cfg.s_data[15:8]};
    assign header_ok_s = (cfg.s_data[31:24] == SyncByte) && (sum_s <= MaxSum);

    assign cfg.s_ready     = ready_s;
    assign cfg.busy        = (state_q != IDLE);
    assign cfg.FrameData   = frame_data_q;
    assign cfg.FrameStrobe = frame_strobe_q;
    assign cfg.done        = done_q;
    assign cfg.err         = err_q;

    // Next-state and next-output decode; strobe, done and err default low so they pulse.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        remaining_d    = remaining_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = StrobeNone;
        done_d         = 1'b0;
        err_d          = 1'b0;
        if (cfg.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s && !header_ok_s) begin
                        err_d = 1'b1;
                    end else if (accept_s) begin
                        index_d     = cfg.s_data[23:16];
                        remaining_d = cfg.s_data[15:8];
                        state_d     = (cfg.s_data[15:8] == 8'd0) ? DONE : LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        frame_data_d = FrameBitsPerRow'(cfg.s_data);
                        state_d      = STROBE;
                    end else begin
                        state_d = LOAD;
                    end
                end
                STROBE: begin
                    frame_strobe_d = StrobeOne << index_q;
                    state_d        = HOLD;
                end
                HOLD: begin
                    remaining_d = remaining_q - 8'd1;
                    index_d     = index_q + 8'd1;
                    state_d     = (remaining_q == 8'd1) ? DONE : LOAD;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q        <= IDLE;
            index_q        <= 8'd0;
            remaining_q    <= 8'd0;
            frame_data_q   <= {FrameBitsPerRow{1'b0}};
            frame_strobe_q <= StrobeNone;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            remaining_q    <= remaining_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end
endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench: stimulus queues the expected strobe/done/err events and a
// monitor pops and compares them whenever the block raises one.
module tb_frame_config_writer;
    localparam logic [1:0] K_STROBE = 2'd0;
    localparam logic [1:0] K_DONE   = 2'd1;
    localparam logic [1:0] K_ERR    = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [19:0] strobe;
        logic [31:0] data;
    } ev_t;

    logic CLK;
    logic resetn;
    ev_t  exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    frame_config_writer_if #(.MaxFramesPerCol(20), .FrameBitsPerRow(32)) cfg ();

    frame_config_writer #(.MaxFramesPerCol(20), .FrameBitsPerRow(32)) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .cfg    (cfg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input int idx, input logic [31:0] data);
        ev_t e;
        e.kind   = kind;
        e.strobe = (kind == K_STROBE) ? (20'h00001 << idx) : 20'h00000;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input logic [1:0] kind);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d strobe=%05h data=%08h, expected none",
                     kind, cfg.FrameStrobe, cfg.FrameData);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.strobe !== cfg.FrameStrobe || e.data !== cfg.FrameData) begin
                errors++;
                $display("FAIL event: got kind=%0d strobe=%05h data=%08h, expected kind=%0d strobe=%05h data=%08h",
                         kind, cfg.FrameStrobe, cfg.FrameData, e.kind, e.strobe, e.data);
            end
        end
    endtask

    // Monitor: sample on the falling edge, compare every visible event.
    always @(negedge CLK) begin
        if (cfg.FrameStrobe != 20'h00000) begin
            chk("strobe_onehot", 32'($countones(cfg.FrameStrobe)), 32'd1);
            check_event(K_STROBE);
        end
        if (cfg.done === 1'b1) check_event(K_DONE);
        if (cfg.err === 1'b1) check_event(K_ERR);
    end

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        cfg.s_data  = w;
        cfg.s_valid = 1'b1;
        while (!cfg.s_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (!cfg.s_ready) begin
            errors++;
            $display("FAIL send_timeout: word %08h not accepted, expected acceptance within 50 cycles", w);
        end else begin
            @(posedge CLK);
            #1;
        end
        cfg.s_valid = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        cfg.s_data  = 32'h0;
        cfg.s_valid = 1'b0;
        cfg.abort   = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(cfg.s_ready), 32'd0);
        chk("rst_data", cfg.FrameData, 32'h0);
        chk("rst_strobe", 32'(cfg.FrameStrobe), 32'h0);
        chk("rst_busy", 32'(cfg.busy), 32'd0);
        chk("rst_done", 32'(cfg.done), 32'd0);
        chk("rst_err", 32'(cfg.err), 32'd0);
        @(posedge CLK);
        #1 resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_release", 32'(cfg.s_ready), 32'd1);

        // Three frames starting at index 2, with latency checks on the first.
        push_ev(K_STROBE, 2, 32'h11111111);
        push_ev(K_STROBE, 3, 32'h22222222);
        push_ev(K_STROBE, 4, 32'h33333333);
        push_ev(K_DONE, 0, 32'h33333333);
        send(32'hA5020300);
        send(32'h11111111);
        @(negedge CLK);
        chk("strobe_before_k1", 32'(cfg.FrameStrobe), 32'h0);
        chk("data_from_k", cfg.FrameData, 32'h11111111);
        chk("ready_in_strobe", 32'(cfg.s_ready), 32'd0);
        chk("busy_in_strobe", 32'(cfg.busy), 32'd1);
        @(negedge CLK);
        chk("strobe_at_k1", 32'(cfg.FrameStrobe), 32'h4);
        send(32'h22222222);
        send(32'h33333333);
        repeat (4) @(negedge CLK);
        chk("busy_after_done", 32'(cfg.busy), 32'd0);

        // Bad sync byte.
        push_ev(K_ERR, 0, 32'h33333333);
        send(32'h5A000100);
        @(negedge CLK);
        chk("ready_after_badsync", 32'(cfg.s_ready), 32'd1);
        chk("busy_after_badsync", 32'(cfg.busy), 32'd0);

        // Range overflow 19+2, then the legal 19+1.
        push_ev(K_ERR, 0, 32'h33333333);
        send(32'hA5130200);
        @(negedge CLK);
        push_ev(K_STROBE, 19, 32'hCAFEF00D);
        push_ev(K_DONE, 0, 32'hCAFEF00D);
        send(32'hA5130100);
        send(32'hCAFEF00D);
        repeat (4) @(negedge CLK);

        // Zero-count header goes straight to DONE.
        push_ev(K_DONE, 0, 32'hCAFEF00D);
        send(32'hA5050000);
        @(negedge CLK);
        chk("ready_in_done", 32'(cfg.s_ready), 32'd0);
        chk("busy_in_done", 32'(cfg.busy), 32'd1);
        chk("done_not_early", 32'(cfg.done), 32'd0);
        @(negedge CLK);
        chk("done_two_after", 32'(cfg.done), 32'd1);
        chk("ready_after_zero", 32'(cfg.s_ready), 32'd1);

        // abort in IDLE blocks acceptance and does nothing else.
        cfg.abort   = 1'b1;
        cfg.s_valid = 1'b1;
        cfg.s_data  = 32'hA5000100;
        @(negedge CLK);
        chk("ready_abort_idle", 32'(cfg.s_ready), 32'd0);
        @(posedge CLK);
        #1;
        cfg.abort   = 1'b0;
        cfg.s_valid = 1'b0;
        @(negedge CLK);
        chk("busy_after_idle_abort", 32'(cfg.busy), 32'd0);

        // abort while the 2nd of 4 strobes is up.
        push_ev(K_STROBE, 0, 32'hA1A1A1A1);
        push_ev(K_STROBE, 1, 32'hB2B2B2B2);
        send(32'hA5000400);
        send(32'hA1A1A1A1);
        send(32'hB2B2B2B2);
        @(posedge CLK);
        #1 cfg.abort = 1'b1;
        @(negedge CLK);
        chk("ready_during_abort", 32'(cfg.s_ready), 32'd0);
        @(posedge CLK);
        #1 cfg.abort = 1'b0;
        @(negedge CLK);
        chk("strobe_after_abort", 32'(cfg.FrameStrobe), 32'h0);
        chk("busy_after_abort", 32'(cfg.busy), 32'd0);
        chk("data_after_abort", cfg.FrameData, 32'hB2B2B2B2);
        chk("ready_after_abort", 32'(cfg.s_ready), 32'd1);
        push_ev(K_STROBE, 7, 32'h0D0D0D0D);
        push_ev(K_DONE, 0, 32'h0D0D0D0D);
        send(32'hA5070100);
        @(negedge CLK);
        chk("busy_fresh_header", 32'(cfg.busy), 32'd1);
        send(32'h0D0D0D0D);
        repeat (4) @(negedge CLK);

        // LOAD stalls on s_valid gaps, then reset lands during HOLD.
        send(32'hA50A0300);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("stall_ready", 32'(cfg.s_ready), 32'd1);
            chk("stall_busy", 32'(cfg.busy), 32'd1);
        end
        push_ev(K_STROBE, 10, 32'h5C5C5C5C);
        send(32'h5C5C5C5C);
        @(posedge CLK);
        #1 resetn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("hold_rst_data", cfg.FrameData, 32'h0);
        chk("hold_rst_strobe", 32'(cfg.FrameStrobe), 32'h0);
        chk("hold_rst_busy", 32'(cfg.busy), 32'd0);
        chk("hold_rst_done", 32'(cfg.done), 32'd0);
        chk("hold_rst_err", 32'(cfg.err), 32'd0);
        chk("hold_rst_ready", 32'(cfg.s_ready), 32'd0);
        @(posedge CLK);
        #1 resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_rerelease", 32'(cfg.s_ready), 32'd1);

        repeat (5) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
